cpu_control_fsm: RTL
====================

// Module: cpu_control_fsm
// PURPOSE
// Multi-cycle control unit of the 8-bit non-pipelined CPU: fetches an instruction, decodes it, and drives the ALU and datapath controls.
// It produces alu_op, alusrc, the immediate and the register/memory strobes.
// The ALU consumes these signals combinationally.
// One instruction completes per FETCH->...->FETCH loop; HALT parks the core until reset.
// PARAMETERS
// DATA_W  8  instruction / data width
// OPC_W   3  opcode width (opcode value == alu_op code)
// IMM_W   3  raw immediate width (sign-extended by datapath)
// REG_AW  2  register-address width (4 registers)
// PORTS
// clk          in   1       system clock, rising edge
// rst          in   1       asynchronous, active-high reset
// instr_in     in   DATA_W  instruction word from instruction memory
// instr_valid  in   1       instr_in valid this cycle (answers instr_req)
// mem_ready    in   1       data memory completed current read/write
// instr_req    out  1       request next instruction
// pc_write     out  1       1-cycle pulse: PC <= PC+1
// alu_op       out  OPC_W   ALU operation (000 ADD, 100 ADDI, 101 SW, 110 LW, 111 SLL)
// alusrc       out  1       0: operand B = read_data2, 1: sign-extended immediate
// imm_out      out  IMM_W   input_sign_extension_immediate = IR[2:0]
// read_reg1    out  REG_AW  IR[4:3]
// read_reg2    out  REG_AW  IR[2:1]
// write_reg    out  REG_AW  IR[4:3]
// mem_read     out  1       data-memory read strobe
// mem_write    out  1       data-memory write strobe
// mem_to_reg   out  1       writeback source: 1 memory, 0 alu_result
// reg_write    out  1       1-cycle register-file write enable
// illegal      out  1       1-cycle pulse on undefined opcode (001, 010)
// halted       out  1       high once HALT (011) executed
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-high.
// - Reset state: state=FETCH, IR=8'h00, halted=0.
// - While rst is high, every output is 0.
// - Instruction format: op=IR[7:5], r1=IR[4:3], r2=IR[2:1], imm=IR[2:0]. r2 and imm overlap by design.
// - Output style: all outputs are Moore, decoded from state and IR.
// - alu_op, alusrc and imm_out are held stable from EXEC through MEM/WB. They are 0 in FETCH/DECODE.
// - FETCH: instr_req=1.
//   - On instr_valid: IR<=instr_in, pc_write=1 for that cycle, -> DECODE.
//   - Otherwise stay in FETCH indefinitely.
// - DECODE:
//   - op 011: -> HALT.
//   - op 001/010: illegal=1 for one cycle, -> FETCH, no other side effects.
//   - Otherwise -> EXEC.
// - EXEC: alu_op=op.
//   - alusrc=0 for ADD; alusrc=1 for ADDI/SLL/LW/SW.
//   - ADD/ADDI/SLL -> WB; LW/SW -> MEM.
// - MEM:
//   - mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready=1.
//   - On mem_ready: LW -> WB, SW -> FETCH.
//   - mem_ready outside MEM is ignored.
// - WB: reg_write=1 for exactly one cycle. mem_to_reg=1 only for LW. -> FETCH.
// - HALT: halted=1, instr_req=0. Only rst exits.
// - Latency with zero wait states (cycles, FETCH accept to next FETCH):
//   - ADD/ADDI/SLL: 4.
//   - SW: 4.
//   - LW: 5.
//   - Each mem_ready-low cycle adds 1.
// - Simultaneous events: instr_valid in a non-FETCH state is ignored.
// - Reset mid-operation (any state) aborts immediately. No partial reg_write/mem_write may follow reset deassertion.
// - mem_read and mem_write are never high together. reg_write and mem_write are never high together.
// STRUCTURE
// - Package cpu_ctrl_pkg holds:
//   - opcode localparams (OP_ADD=000, OP_ADDI=100, OP_SW=101, OP_LW=110, OP_SLL=111, OP_HALT=011);
//   - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT);
//   - instruction field bit positions.
// - Sub-module: cpu_opcode_class, combinational op -> {is_alu, is_load, is_store, is_halt, is_illegal, use_imm}.
// - The FSM registers are the only state (state, IR, halted).
// TESTING
// - ADD: instr_in=8'h0C, valid on cycle 1 -> EXEC has alu_op=000, alusrc=0, read_reg1=01, read_reg2=10; WB reg_write=1, write_reg=01, mem_to_reg=0; back to FETCH 4 cycles after accept.
// - ADDI: 8'h86 -> EXEC has alu_op=100, alusrc=1, imm_out=3'b110; WB reg_write=1, write_reg=00.
// - LW with waits: 8'hD5, mem_ready low 3 cycles then high -> mem_read high 4 cycles, alu_op=110, imm_out=101; then WB reg_write=1, mem_to_reg=1, write_reg=10.
// - SW: 8'hAB, mem_ready=1 at once -> mem_write high 1 cycle, alu_op=101, imm_out=011; reg_write never asserts; FETCH next.
// - HALT/illegal: 8'h20 -> illegal pulses 1 cycle, FETCH resumes; 8'h60 -> halted=1, instr_req stays 0 for 20 cycles.
// - Reset: rst asserted mid-MEM of LW -> all outputs 0 immediately; after release, state=FETCH, instr_req=1, no reg_write.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// cpu_ctrl_pkg: shared definitions for the CPU control unit.
//   - datapath widths
//   - opcode values (an opcode is also its alu_op code)
//   - FSM state encoding
//   - opcode class struct
//   - instruction field bit positions
package cpu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;
  localparam int IMM_W  = 3;
  localparam int REG_AW = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'b100;
  localparam logic [OPC_W-1:0] OP_SW   = 3'b101;
  localparam logic [OPC_W-1:0] OP_LW   = 3'b110;
  localparam logic [OPC_W-1:0] OP_SLL  = 3'b111;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b011;

  // Instruction layout: op=IR[7:5], r1=IR[4:3], r2=IR[2:1], imm=IR[2:0].
  // r2 and imm deliberately overlap.
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int R1_MSB  = 4;
  localparam int R1_LSB  = 3;
  localparam int R2_MSB  = 2;
  localparam int R2_LSB  = 1;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_halt;
    logic is_illegal;
    logic use_imm;
  } op_class_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// cpu_ctrl_if: instruction fetch, data-memory handshake and datapath control
// bundle between the control unit (master) and the datapath/memories (slave).
//   instr_in/instr_valid/mem_ready : datapath -> control
//   everything else                : control -> datapath
interface cpu_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic [DATA_W-1:0] instr_in;
  logic              instr_valid;
  logic              mem_ready;
  logic              instr_req;
  logic              pc_write;
  logic [OPC_W-1:0]  alu_op;
  logic              alusrc;
  logic [IMM_W-1:0]  imm_out;
  logic [REG_AW-1:0] read_reg1;
  logic [REG_AW-1:0] read_reg2;
  logic [REG_AW-1:0] write_reg;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic              reg_write;
  logic              illegal;
  logic              halted;

  modport master (
    input  instr_in, instr_valid, mem_ready,
    output instr_req, pc_write, alu_op, alusrc, imm_out,
           read_reg1, read_reg2, write_reg,
           mem_read, mem_write, mem_to_reg, reg_write, illegal, halted
  );

  modport slave (
    output instr_in, instr_valid, mem_ready,
    input  instr_req, pc_write, alu_op, alusrc, imm_out,
           read_reg1, read_reg2, write_reg,
           mem_read, mem_write, mem_to_reg, reg_write, illegal, halted
  );

endinterface

// File: rtl/cpu_control_fsm_opcode_class.sv
// cpu_opcode_class: combinational opcode classifier.
//   op  in   opcode field of the instruction register
//   cls out  {is_alu, is_load, is_store, is_halt, is_illegal, use_imm}
module cpu_opcode_class
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] op,
  output op_class_t        cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_ADD:  cls.is_alu = 1'b1;
      OP_ADDI: begin cls.is_alu = 1'b1; cls.use_imm = 1'b1; end
      OP_SLL:  begin cls.is_alu = 1'b1; cls.use_imm = 1'b1; end
      OP_LW:   begin cls.is_load = 1'b1; cls.use_imm = 1'b1; end
      OP_SW:   begin cls.is_store = 1'b1; cls.use_imm = 1'b1; end
      OP_HALT: cls.is_halt = 1'b1;
      default: cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit of the 8-bit non-pipelined CPU.
// Fetches an instruction into IR, decodes it and sequences ALU, data memory
// and register-file writeback. HALT parks the core until reset.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset; all outputs forced to 0 while high
//   bus  cpu_ctrl_if.master (fetch, memory handshake, datapath controls)
//
// state  | meaning
// FETCH  | request instruction; latch IR and pulse pc_write on instr_valid
// DECODE | classify opcode; illegal pulses here, HALT branches here
// EXEC   | drive alu_op/alusrc/imm_out
// MEM    | LW/SW strobe held until mem_ready
// WB     | one-cycle reg_write, mem_to_reg for LW
// HALT   | halted=1, no fetch; only rst exits
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic              halted_q;
  op_class_t         cls;

  logic              instr_req_c, pc_write_c, alusrc_c;
  logic [OPC_W-1:0]  alu_op_c;
  logic [IMM_W-1:0]  imm_c;
  logic              mem_read_c, mem_write_c, mem_to_reg_c, reg_write_c, illegal_c;

  cpu_opcode_class u_opclass (
    .op  (ir_q[OP_MSB:OP_LSB]),
    .cls (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && bus.instr_valid) ir_q <= bus.instr_in;
      if (state_q == ST_DECODE && cls.is_halt) halted_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_req_c  = 1'b0;
    pc_write_c   = 1'b0;
    alu_op_c     = '0;
    alusrc_c     = 1'b0;
    imm_c        = '0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;

    // ALU controls stay stable from EXEC through the end of MEM/WB so the
    // combinational ALU result feeding memory address/writeback cannot glitch.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_op_c = ir_q[OP_MSB:OP_LSB];
      alusrc_c = cls.use_imm;
      imm_c    = ir_q[IMM_MSB:IMM_LSB];
    end

    case (state_q)
      ST_FETCH: begin
        instr_req_c = 1'b1;
        if (bus.instr_valid) begin
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.is_halt) begin
          state_d = ST_HALT;
        end else if (cls.is_illegal) begin
          illegal_c = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = cls.is_alu ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        mem_read_c  = cls.is_load;
        mem_write_c = cls.is_store;
        if (bus.mem_ready) state_d = cls.is_load ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = cls.is_load;
        state_d      = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Outputs are gated by rst so nothing (including the FETCH request) is
  // visible while reset is held.
  assign bus.instr_req  = instr_req_c & ~rst;
  assign bus.pc_write   = pc_write_c & ~rst;
  assign bus.alu_op     = rst ? '0 : alu_op_c;
  assign bus.alusrc     = alusrc_c & ~rst;
  assign bus.imm_out    = rst ? '0 : imm_c;
  assign bus.read_reg1  = rst ? '0 : ir_q[R1_MSB:R1_LSB];
  assign bus.read_reg2  = rst ? '0 : ir_q[R2_MSB:R2_LSB];
  assign bus.write_reg  = rst ? '0 : ir_q[R1_MSB:R1_LSB];
  assign bus.mem_read   = mem_read_c & ~rst;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.mem_to_reg = mem_to_reg_c & ~rst;
  assign bus.reg_write  = reg_write_c & ~rst;
  assign bus.illegal    = illegal_c & ~rst;
  assign bus.halted     = halted_q & ~rst;

endmodule
